serial_parity_checker: RTL and testbench
========================================

# serial_parity_checker

Receive side of the team's XOR parity link: accepts a serial bit stream framed by a start-of-frame marker, rebuilds each DATA_W-bit word LSB-first, and XOR-reduces the data bits against the trailing parity bit. Reports the word, a parity verdict and framing errors to downstream logic. It sits behind a serial parity generator, which XOR-reduces the word and appends the result. The counterpart to the gate-level XOR primitives in the combinational library.

## Interface
- DATA_W, 8, data bits per frame (2..32)
- ODD, 0, 0 = even parity (data XOR parity == 0 is good), 1 = odd parity (== 1 is good)
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_bit  input  1  serial bit, sampled only when in_valid=1
- in_valid  input  1  in_bit is valid this cycle; gaps of any length allowed
- in_sof  input  1  qualifies in_valid: this bit is data bit 0 of a new frame
- out_data  output  DATA_W  reassembled word, held until next out_valid
- out_valid  output  1  one-cycle pulse, word + verdict valid
- parity_err  output  1  valid with out_valid: 1 = parity mismatch
- frame_err  output  1  one-cycle pulse: frame aborted by premature in_sof
- err_count  output  8  saturating count of parity_err + frame_err events

## Operation
- States: IDLE, DATA, PARITY. Only accepted bits (in_valid=1) advance state.
- IDLE: in_valid with in_sof=0 ignored. in_valid with in_sof=1 causes the following: store bit at position 0, running XOR := in_bit, bit counter := 1, go to DATA. If DATA_W=1, go to PARITY instead.
- DATA: each accepted bit is stored at position = counter, XORed into running parity, and the counter is incremented. After bit DATA_W-1 is accepted, go to PARITY.
- PARITY: the accepted bit is the parity bit. Then:
  - out_data := shift register contents
  - parity_err := (running XOR ^ in_bit) != ODD
  - out_valid pulses
  - go to IDLE
- in_sof=1 on an accepted bit while in DATA or PARITY causes the following:
  - the current frame is discarded with no out_valid
  - frame_err pulses
  - the bit is taken as bit 0 of a new frame, same as the IDLE sof case
  - the state becomes DATA
- err_count is incremented by 1 on each out_valid with parity_err=1 and by 1 on each frame_err pulse. Both events cannot occur in the same cycle. It holds at 255.
- in_sof with in_valid=0 is ignored.

## Timing
- Reset values: state=IDLE, counter=0, running XOR=0, out_data=0, out_valid=0, parity_err=0, frame_err=0, err_count=0.
- rst asserted mid-frame causes the following: immediate return to reset values, the partial frame is lost, and no pulses are emitted.
- Latency: out_valid, out_data and parity_err update on the clock edge that samples the parity bit. They are visible in the cycle after in_valid for that bit.
- Throughput: back-to-back frames at in_valid=1 every cycle. The sof bit of frame n+1 may be accepted in the cycle immediately after the parity bit of frame n.
- frame_err is registered on the edge that samples the offending sof bit. It is a one-cycle pulse.
- out_data and parity_err hold their values between out_valid pulses. parity_err is meaningful only when out_valid=1.
- Counter width is clog2(DATA_W+1). There is no wrap inside a frame.

## Test plan
- DATA_W=8, ODD=0: send 0xA5 LSB-first (1,0,1,0,0,1,0,1), sof on the first bit, then parity 0. Required: out_valid one cycle after the parity bit, out_data=0xA5, parity_err=0, err_count=0.
- Same frame with parity bit 1. Required: out_data=0xA5, parity_err=1, err_count=1. Then send 0x01 with parity 1. Required: parity_err=0, and err_count stays 1.
- 0x3C with random in_valid gaps of 0–3 cycles and in_bit toggling during gaps. Required: out_data=0x3C, parity_err=0, exactly one out_valid pulse.
- After 5 data bits, assert in_sof with bit 1 and then send 0xFF with parity 0. Required: a frame_err pulse on the sof bit, no out_valid for the aborted frame, then out_data=0xFF, parity_err=0, err_count=1.
- Assert rst for one cycle after 3 bits, then send 0x00 with parity 0. Required: all outputs reset, then out_data=0x00, parity_err=0, no frame_err. Separately, drive 300 parity-error frames. Required: err_count saturates at 255.
- ODD=1, back-to-back frames 0x80/par0 then 0x81/par1 with no idle cycle. Required: out_valid on two pulses, parity_err=0 for 0x80 (one 1-bit, parity 0, total odd) and parity_err=0 for 0x81 (two 1-bits, parity 1, total odd).

Source files
------------

// File: rtl/serial_parity_checker.sv
// Serial XOR parity receiver: rebuilds LSB-first DATA_W-bit words framed by in_sof,
// checks the trailing parity bit, and flags aborted frames with a saturating error count.
module serial_parity_checker #(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic [7:0]        err_count
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned ERR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic               r_xor, w_xor;
  logic [DATA_W-1:0]  r_shreg, w_shreg;
  logic [DATA_W-1:0]  r_data, w_data;
  logic               r_valid, w_valid;
  logic               r_perr, w_perr;
  logic               r_ferr, w_ferr;
  logic [ERR_W-1:0]   r_err_count, w_err_count;
  logic               w_err_inc;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_xor       <= 1'b0;
      r_shreg     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_xor       <= w_xor;
      r_shreg     <= w_shreg;
      r_data      <= w_data;
      r_valid     <= w_valid;
      r_perr      <= w_perr;
      r_ferr      <= w_ferr;
      r_err_count <= w_err_count;
    end
  end

  // Next-state and next-output logic; only accepted bits move the frame forward
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_xor     = r_xor;
    w_shreg   = r_shreg;
    w_data    = r_data;
    w_perr    = r_perr;
    w_valid   = 1'b0;
    w_ferr    = 1'b0;
    w_err_inc = 1'b0;

    if (in_valid) begin
      if (in_sof) begin
        // A start bit always begins a new frame; mid-frame it also aborts the old one
        w_ferr     = (r_state != IDLE);
        w_err_inc  = (r_state != IDLE);
        w_shreg    = '0;
        w_shreg[0] = in_bit;
        w_xor      = in_bit;
        w_cnt      = CNT_W'(1);
        w_state    = (DATA_W == 1) ? PARITY : DATA;
      end else begin
        case (r_state)
          IDLE: begin
          end
          DATA: begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
              if (r_cnt == CNT_W'(i)) w_shreg[i] = in_bit;
            end
            w_xor = r_xor ^ in_bit;
            w_cnt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DATA_W - 1)) w_state = PARITY;
          end
          PARITY: begin
            w_data    = r_shreg;
            w_perr    = (r_xor ^ in_bit) ^ ODD;
            w_valid   = 1'b1;
            w_err_inc = (r_xor ^ in_bit) ^ ODD;
            w_cnt     = '0;
            w_xor     = 1'b0;
            w_state   = IDLE;
          end
          default: begin
            w_state = IDLE;
          end
        endcase
      end
    end

    w_err_count = r_err_count;
    if (w_err_inc && (r_err_count != {ERR_W{1'b1}})) begin
      w_err_count = r_err_count + ERR_W'(1);
    end
  end

  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: table of frames on an even-parity instance,
// plus hand sequences for gaps, aborts, reset, saturation and odd-parity back-to-back frames.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_bit, in_valid, in_sof;
  logic [7:0] e_data, o_data;
  logic       e_valid, o_valid, e_perr, o_perr, e_ferr, o_ferr;
  logic [7:0] e_ec, o_ec;

  int checks = 0;
  int errors = 0;
  int e_ov_cnt = 0, e_fe_cnt = 0, o_ov_cnt = 0;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
    .out_data(e_data), .out_valid(e_valid), .parity_err(e_perr),
    .frame_err(e_ferr), .err_count(e_ec)
  );

  serial_parity_checker #(.DATA_W(8), .ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_sof(in_sof),
    .out_data(o_data), .out_valid(o_valid), .parity_err(o_perr),
    .frame_err(o_ferr), .err_count(o_ec)
  );

  // Pulse counters, sampled just after the active edge
  always @(posedge clk) begin
    #1;
    if (e_valid === 1'b1) e_ov_cnt++;
    if (e_ferr === 1'b1)  e_fe_cnt++;
    if (o_valid === 1'b1) o_ov_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       exp_perr;
    logic [7:0] exp_ec;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic b, input logic sof);
    in_valid = 1'b1;
    in_bit   = b;
    in_sof   = sof;
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Data bits LSB-first with sof on bit 0, then parity; first_now drives bit 0 without waiting
  task automatic send_frame(input logic [7:0] d, input logic p, input bit first_now, input int max_gap);
    logic [8:0] bits;
    int         n;
    bits = {p, d};
    for (int i = 0; i < 9; i++) begin
      if (i > 0 || !first_now) begin
        if (i > 0) begin
          n = int'($urandom_range(0, max_gap));
          for (int g = 0; g < n; g++) begin
            step();
            in_valid = 1'b0;
            in_bit   = 1'($urandom);
            in_sof   = 1'($urandom);
          end
        end
        step();
      end
      drive(bits[i], (i == 0));
    end
  endtask

  initial begin
    int ov0, fe0, oo0;
    logic [4:0] partial;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'd1};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 8'd1};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 8'd1};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'd2};
    vecs[5] = '{8'h7E, 1'b0, 1'b0, 8'd2};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 8'd3};
    vecs[7] = '{8'hC3, 1'b0, 1'b0, 8'd3};

    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    step(); step();
    chk("reset out_valid", 32'(e_valid), 32'd0);
    chk("reset out_data", 32'(e_data), 32'd0);
    chk("reset err_count", 32'(e_ec), 32'd0);
    chk("reset frame_err", 32'(e_ferr), 32'd0);
    rst = 1'b0;
    step();

    // Table-driven frames on the even-parity instance
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].data, vecs[v].par, 1'b0, 0);
      step();
      go_idle();
      chk($sformatf("vec%0d out_valid", v), 32'(e_valid), 32'd1);
      chk($sformatf("vec%0d out_data", v), 32'(e_data), 32'(vecs[v].data));
      chk($sformatf("vec%0d parity_err", v), 32'(e_perr), 32'(vecs[v].exp_perr));
      chk($sformatf("vec%0d err_count", v), 32'(e_ec), 32'(vecs[v].exp_ec));
      step();
      chk($sformatf("vec%0d pulse width", v), 32'(e_valid), 32'd0);
      chk($sformatf("vec%0d data hold", v), 32'(e_data), 32'(vecs[v].data));
    end

    // Gapped frame with noise on in_bit/in_sof during gaps
    ov0 = e_ov_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 3);
    step(); go_idle();
    step(); step(); step();
    chk("gap out_data", 32'(e_data), 32'h3C);
    chk("gap parity_err", 32'(e_perr), 32'd0);
    chk("gap pulse count", 32'(e_ov_cnt - ov0), 32'd1);
    chk("gap err_count", 32'(e_ec), 32'd3);

    // Abort after 5 data bits by a new sof carrying bit 1
    ov0 = e_ov_cnt; fe0 = e_fe_cnt;
    partial = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      step();
      drive(partial[i], (i == 0));
    end
    step();
    drive(1'b1, 1'b1);
    step();
    chk("abort frame_err pulse", 32'(e_ferr), 32'd1);
    chk("abort err_count", 32'(e_ec), 32'd4);
    drive(1'b1, 1'b0);
    for (int i = 2; i < 8; i++) begin
      step();
      drive(1'b1, 1'b0);
    end
    step();
    drive(1'b0, 1'b0);
    step(); go_idle();
    chk("abort new out_valid", 32'(e_valid), 32'd1);
    chk("abort new out_data", 32'(e_data), 32'hFF);
    chk("abort new parity_err", 32'(e_perr), 32'd0);
    step();
    chk("abort pulse counts ov", 32'(e_ov_cnt - ov0), 32'd1);
    chk("abort pulse counts fe", 32'(e_fe_cnt - fe0), 32'd1);
    chk("abort err_count final", 32'(e_ec), 32'd4);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'b1, (i == 0));
    end
    step(); go_idle();
    rst = 1'b1;
    #1;
    chk("midreset out_data", 32'(e_data), 32'd0);
    chk("midreset err_count", 32'(e_ec), 32'd0);
    chk("midreset parity_err", 32'(e_perr), 32'd0);
    step();
    rst = 1'b0;
    ov0 = e_ov_cnt; fe0 = e_fe_cnt;
    send_frame(8'h00, 1'b0, 1'b0, 0);
    step(); go_idle();
    chk("postreset out_valid", 32'(e_valid), 32'd1);
    chk("postreset out_data", 32'(e_data), 32'd0);
    chk("postreset parity_err", 32'(e_perr), 32'd0);
    step();
    chk("postreset frame_err count", 32'(e_fe_cnt - fe0), 32'd0);
    chk("postreset out_valid count", 32'(e_ov_cnt - ov0), 32'd1);
    chk("postreset err_count", 32'(e_ec), 32'd0);

    // 300 back-to-back parity-error frames saturate the counter
    for (int f = 0; f < 300; f++) begin
      send_frame(8'h01, 1'b0, 1'b0, 0);
      if (f == 253) begin
        step(); go_idle();
        chk("sat err_count 254", 32'(e_ec), 32'd254);
      end
    end
    step(); go_idle();
    chk("sat parity_err", 32'(e_perr), 32'd1);
    chk("sat err_count", 32'(e_ec), 32'd255);

    // Odd parity, back-to-back frames with no idle cycle
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    oo0 = o_ov_cnt;
    send_frame(8'h80, 1'b0, 1'b0, 0);
    step();
    chk("odd 0x80 out_valid", 32'(o_valid), 32'd1);
    chk("odd 0x80 out_data", 32'(o_data), 32'h80);
    chk("odd 0x80 parity_err", 32'(o_perr), 32'd0);
    send_frame(8'h81, 1'b1, 1'b1, 0);
    step(); go_idle();
    chk("odd 0x81 out_valid", 32'(o_valid), 32'd1);
    chk("odd 0x81 out_data", 32'(o_data), 32'h81);
    chk("odd 0x81 parity_err", 32'(o_perr), 32'd0);
    step();
    chk("odd pulse count", 32'(o_ov_cnt - oo0), 32'd2);
    chk("odd err_count", 32'(o_ec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
